// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampled UART receiver:
// FSM state encoding, word-length decode and expected-parity calculation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    // 00..11 selects 5..8 data bits.
    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return {2'b00, wls} + 4'd5;
    endfunction

    function automatic logic exp_parity(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       sticky);
        logic [7:0] mask;
        logic       odd;
        mask = ~(8'hFF << wls_to_bits(wls));
        odd  = ^(data & mask);
        if (sticky)
            return ~eps;
        return eps ? odd : ~odd;
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Input synchroniser for the asynchronous serial line plus a 3-tick sample
// history whose majority filters single-tick noise.
module uart_rx_vote #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_baud_pulse,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_vote
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_hist;

    // Synchroniser and history reset to the idle (mark) level so no false start follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_hist <= 3'b111;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            if (i_baud_pulse)
                r_hist <= {r_hist[1:0], r_sync[SYNC_STAGES-1]};
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];
    assign o_vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

endmodule

// File: rtl/uart_rx_os.sv
// 16550-style oversampled serial receiver: start validation, majority-voted
// bit decisions, 5-8 data bits, optional/sticky parity and break recovery.
module uart_rx_os
    import uart_rx_pkg::*;
#(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] rx_data,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    localparam int              CW   = $clog2(OSR);
    localparam logic [CW-1:0]   MID  = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0]   FULL = CW'(OSR - 1);

    logic            w_rx_s, w_vote;
    rx_state_t       r_state, w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [3:0]      r_nbits;
    logic [7:0]      r_data;
    logic [1:0]      r_wls;
    logic            r_pen, r_eps, r_sticky;
    logic            r_par_bit, r_pe;
    logic            w_tick_mid, w_tick_full, w_last_bit;
    logic            w_cnt_clr, w_start_ok, w_data_bit, w_par_dec, w_stop_dec;

    uart_rx_vote #(.SYNC_STAGES(SYNC_STAGES)) u_vote (
        .clk          (clk),
        .rst          (rst),
        .i_baud_pulse (baud_pulse),
        .i_rx         (rx),
        .o_rx_s       (w_rx_s),
        .o_vote       (w_vote)
    );

    assign w_tick_mid  = baud_pulse && (r_cnt == MID);
    assign w_tick_full = baud_pulse && (r_cnt == FULL);
    assign w_last_bit  = ({1'b0, r_bit_idx} == (r_nbits - 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_start_ok   = 1'b0;
        w_data_bit   = 1'b0;
        w_par_dec    = 1'b0;
        w_stop_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (baud_pulse && !w_rx_s)
                    w_state_next = ST_START;
            end
            ST_START: if (w_tick_mid) begin
                w_cnt_clr    = 1'b1;
                w_start_ok   = !w_vote;
                w_state_next = w_vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (w_tick_full) begin
                w_cnt_clr  = 1'b1;
                w_data_bit = 1'b1;
                if (w_last_bit)
                    w_state_next = r_pen ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_tick_full) begin
                w_cnt_clr    = 1'b1;
                w_par_dec    = 1'b1;
                w_state_next = ST_STOP;
            end
            ST_STOP: if (w_tick_full) begin
                w_cnt_clr    = 1'b1;
                w_stop_dec   = 1'b1;
                w_state_next = w_vote ? ST_IDLE : ST_BRK_WAIT;
            end
            ST_BRK_WAIT: begin
                w_cnt_clr = 1'b1;
                if (baud_pulse && w_rx_s)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_nbits   <= 4'd5;
            r_data    <= '0;
            r_wls     <= '0;
            r_pen     <= 1'b0;
            r_eps     <= 1'b0;
            r_sticky  <= 1'b0;
            r_par_bit <= 1'b0;
            r_pe      <= 1'b0;
            push      <= 1'b0;
            rx_data   <= '0;
            pe        <= 1'b0;
            fe        <= 1'b0;
            bi        <= 1'b0;
        end else begin
            if (baud_pulse)
                r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            // Configuration is frozen at the validated start bit.
            if (w_start_ok) begin
                r_wls     <= wls;
                r_nbits   <= wls_to_bits(wls);
                r_pen     <= pen;
                r_eps     <= eps;
                r_sticky  <= sticky_parity;
                r_data    <= '0;
                r_bit_idx <= '0;
                r_par_bit <= 1'b0;
                r_pe      <= 1'b0;
            end
            if (w_data_bit) begin
                r_data[r_bit_idx] <= w_vote;
                r_bit_idx         <= r_bit_idx + 3'd1;
            end
            if (w_par_dec) begin
                r_par_bit <= w_vote;
                r_pe      <= (w_vote != exp_parity(r_data, r_wls, r_eps, r_sticky));
            end
            push <= w_stop_dec;
            if (w_stop_dec) begin
                rx_data <= r_data;
                pe      <= r_pe;
                fe      <= ~w_vote;
                bi      <= ~w_vote && (r_data == 8'h00) && !r_par_bit;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames push expected characters
// into a queue; a monitor pops and compares on every push.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 96; // 16 ticks x 6 clk

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    logic       clk, rst, baud_pulse, rx, pen, eps, sticky_parity;
    logic [1:0] wls;
    logic       push, pe, fe, bi;
    logic [7:0] rx_data;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_os #(.OSR(16), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .wls           (wls),
        .push          (push),
        .rx_data       (rx_data),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_pulse = 1'b0;
        forever begin
            repeat (5) @(negedge clk);
            baud_pulse = 1'b1;
            @(negedge clk);
            baud_pulse = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every push must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && push) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_push: got data 0x%0h fe %0b bi %0b, expected no push",
                         rx_data, fe, bi);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("pe",      32'(pe),      32'(e.pe));
                check("fe",      32'(fe),      32'(e.fe));
                check("bi",      32'(bi),      32'(e.bi));
            end
        end
    end

    task automatic hold_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
        wls = w; pen = p; eps = e; sticky_parity = s;
    endtask

    // Sends one frame; glitch_bit >= 0 puts a one-tick high pulse mid-way through that data bit.
    task automatic send_frame(input int nbits, input logic [7:0] data, input logic use_par,
                              input logic par_bit, input logic stop_bit, input int glitch_bit);
        rx = 1'b0;
        hold_bits(1);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            if (i == glitch_bit) begin
                repeat (45) @(negedge clk);
                rx = 1'b1;
                repeat (6) @(negedge clk);
                rx = data[i];
                repeat (BIT_CLKS - 51) @(negedge clk);
            end else begin
                hold_bits(1);
            end
        end
        if (use_par) begin
            rx = par_bit;
            hold_bits(1);
        end
        rx = stop_bit;
        hold_bits(1);
        rx = 1'b1;
        hold_bits(2);
    endtask

    task automatic expect_char(input logic [7:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        e.data = d; e.pe = p; e.fe = f; e.bi = b;
        q.push_back(e);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("reset_push",    32'(push),    32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_flags",   32'({pe, fe, bi}), 32'd0);
        rst = 1'b0;
        hold_bits(1);

        // 8O1 0x45 (three ones): odd parity bit is 0, so clean.
        set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
        expect_char(8'h45, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8'h45, 1'b1, 1'b0, 1'b1, -1);

        // 8E1 0x45 with parity 0: even parity needs 1.
        set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
        expect_char(8'h45, 1'b1, 1'b0, 1'b0);
        send_frame(8, 8'h45, 1'b1, 1'b0, 1'b1, -1);

        // 5N1 0x1F: upper bits must read 0.
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        expect_char(8'h1F, 1'b0, 1'b0, 1'b0);
        send_frame(5, 8'h1F, 1'b0, 1'b0, 1'b1, -1);

        // 5-bit sticky parity with eps=0 expects a 1; received 0.
        set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
        expect_char(8'h1F, 1'b1, 1'b0, 1'b0);
        send_frame(5, 8'h1F, 1'b1, 1'b0, 1'b1, -1);

        // False start: 4-tick low pulse, then idle. No character expected.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (24) @(negedge clk);
        rx = 1'b1;
        hold_bits(3);

        expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, -1);

        // One-tick glitch inside data bit 3 of 0x00.
        expect_char(8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8'h00, 1'b0, 1'b0, 1'b1, 3);

        // Framing error without break: 0x81 with a low stop bit.
        expect_char(8'h81, 1'b0, 1'b1, 1'b0);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, -1);

        // Break: line low for two frame times, one break character only.
        expect_char(8'h00, 1'b0, 1'b1, 1'b1);
        rx = 1'b0;
        hold_bits(20);
        rx = 1'b1;
        hold_bits(2);
        expect_char(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, -1);

        // 7E1 0x3B (five ones): even parity bit 1, clean.
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        expect_char(8'h3B, 1'b0, 1'b0, 1'b0);
        send_frame(7, 8'h3B, 1'b1, 1'b1, 1'b1, -1);

        // Config change mid-frame must not affect the frame in flight.
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        expect_char(8'hC3, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
            begin
                hold_bits(3);
                set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
            end
        join
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame aborts without a push.
        rx = 1'b0;
        hold_bits(1);
        rx = 1'b1;
        hold_bits(1);
        rx = 1'b0;
        hold_bits(1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_push",    32'(push),    32'd0);
        rst = 1'b0;
        hold_bits(2);
        expect_char(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1, -1);

        for (int i = 0; i < 2000 && q.size() != 0; i++)
            @(negedge clk);
        check("outstanding_expectations", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised 16550-style serial receiver: oversampled start detection, 3-sample majority voting per bit, false-start rejection, 5–8 data bits, optional/sticky parity, and a break-recovery state. It sits between the baud generator (`baud_pulse`) and the receive FIFO, producing one `push` per character with its data and error flags. It generalises the fixed 16x receiver with a configurable oversampling ratio, an input synchroniser, noise filtering and a parallel data output.

## Interface
Parameters:
- `OSR`, 16, baud ticks per bit. Must be even and at least 8.
- `SYNC_STAGES`, 2, number of `rx` synchroniser flops (minimum 2).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `baud_pulse`  in  1  one-`clk` oversample tick enable
- `rx`  in  1  serial line, asynchronous, idles high
- `pen`  in  1  parity enable
- `eps`  in  1  even parity select
- `sticky_parity`  in  1  stick parity
- `wls`  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- `push`  out  1  one-`clk` strobe, character complete
- `rx_data`  out  8  received character, LSB-aligned, unused MSBs 0
- `pe`  out  1  parity error, qualifies `rx_data`
- `fe`  out  1  framing error (first stop bit sampled 0)
- `bi`  out  1  break indication

## Operation
- `rx` passes through `SYNC_STAGES` flops to give `rx_s`. A 3-bit shift register captures `rx_s` on every `baud_pulse`. The majority of the three bits gives `vote`.
- Tick counter width is `$clog2(OSR)`. The counter advances only on `baud_pulse`.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: on `baud_pulse` with `rx_s`=0, clear the counter and go to START.
- START: at tick `OSR/2`, evaluate `vote`.
  - `vote`=1 is a false start: return to IDLE with no `push`.
  - `vote`=0: latch `wls`, `pen`, `eps` and `sticky_parity`, clear the counter and go to DATA.
- Bit decisions: every subsequent decision occurs `OSR` ticks after the previous one, using `vote`.
- DATA: shift in LSB first. Go to PARITY after `wls`+5 bits if latched `pen`=1, otherwise go to STOP.
- Expected parity:
  - `sticky_parity`=1: expected bit is ~`eps`.
  - `eps`=1: expected bit is ^data.
  - `eps`=0: expected bit is ~^data.
  - `pe` = received bit ≠ expected bit.
- STOP: `fe` = ~`vote`.
- `bi` = 1 when all data bits, the parity bit (if enabled) and the stop bit are 0. `bi`=1 implies `fe`=1.
- After STOP: go to IDLE if the stop `vote` is 1, otherwise go to BRK_WAIT.
- BRK_WAIT: go to IDLE on the first `baud_pulse` with `rx_s`=1. A falling edge cannot start a new frame until then.
- Only the first stop bit is checked. A new start may be detected on the tick after the stop decision.
- Config inputs changing mid-frame have no effect until the next validated start.

## Timing
- Reset values: `push`, `pe`, `fe`, `bi` = 0 and `rx_data` = 0. State is IDLE, counter 0, vote register 3'b111, synchroniser flops 1.
- Reset asserted mid-frame aborts the frame immediately. No `push` is produced.
- `push` is registered. It asserts for exactly one `clk`, in the cycle after the `baud_pulse` that makes the stop decision.
- `rx_data`, `pe`, `fe` and `bi` update in the same cycle as `push` and hold until the next `push`.
- Start-to-push: the stop decision falls (wls+6+pen)·`OSR` + `OSR/2` ticks after the start-detect tick, excluding synchroniser latency (`SYNC_STAGES` clk).
- A glitch shorter than 2 consecutive ticks at mid-bit does not change the decided value.
- `baud_pulse` held high on consecutive clocks counts one tick per clock.

## Structure
- Package `uart_rx_pkg`:
  - `rx_state_t` enum.
  - `wls` → bit-count function.
  - Expected-parity function over (data, wls, eps, sticky).
- Sub-module `uart_rx_vote`: synchroniser plus 3-tick shift register and majority output. Parametrised by `SYNC_STAGES`.
- Top level `uart_rx_os`: FSM, tick counter, data shifter and flag logic.

## Test plan
All scenarios use `clk` at 100 MHz, `baud_pulse` every 6 clk and `OSR`=16.
- 8O1, data 0x45, parity bit 0 → one `push`, `rx_data`=0x45, `pe`=`fe`=`bi`=0.
- 8E1, data 0x45 sent with parity bit 0 → `push`, `rx_data`=0x45, `pe`=1.
- 5N1 (`wls`=00, `pen`=0), data 0x1F → `rx_data`=0x1F with upper bits 0. Sticky parity with `eps`=0 and received parity 0 → `pe`=1.
- Start pulse 4 ticks wide, then line high → no `push`, FSM back in IDLE. A following valid frame 0xA5 is received correctly.
- Single-tick glitch at mid-bit of data bit 3 of 0x00 → `rx_data`=0x00 and no errors.
- Line held low for 2 frame times, then high, then frame 0x5A:
  - First `push` gives `bi`=1, `fe`=1, `rx_data`=0.
  - No `push` while the line stays low.
  - Second `push` gives 0x5A with clean flags.
  - Reset pulsed mid-frame → no `push`; the next frame is received correctly.
